// File: rtl/l1_cache_pkg.sv
// l1_cache_pkg: shared geometry, FSM states and line type for the L1 data cache.
package l1_cache_pkg;
  localparam int L1_DATA_WIDTH = 32;
  localparam int L1_ADDR_WIDTH = 11;
  localparam int L1_BLOCK_SIZE = 32;
  localparam int L1_NUM_LINES  = 8;
  localparam int OFFSET_W = $clog2(L1_BLOCK_SIZE);
  localparam int INDEX_W  = $clog2(L1_NUM_LINES);
  localparam int TAG_W    = L1_ADDR_WIDTH - OFFSET_W - INDEX_W;
  typedef enum logic [1:0] {IDLE, L2_READ, L2_WRITE, RESP} state_t;
  typedef logic [L1_BLOCK_SIZE-1:0][L1_DATA_WIDTH-1:0] block_t;
endpackage

// File: rtl/l1_tag_array.sv
// l1_tag_array: tag/valid store with combinational hit lookup and synchronous install.
module l1_tag_array import l1_cache_pkg::*; (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] idx_i,
  input  logic [TAG_W-1:0]   tag_i,
  output logic               hit_o,
  input  logic               we_i,
  input  logic [INDEX_W-1:0] widx_i,
  input  logic [TAG_W-1:0]   wtag_i
);
  logic [2**INDEX_W-1:0] valid_q;
  logic [TAG_W-1:0]      tag_q [2**INDEX_W];
  assign hit_o = valid_q[idx_i] && tag_q[idx_i] == tag_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) valid_q <= '0;
    else if (we_i) valid_q[widx_i] <= 1'b1;
  always_ff @(posedge clk)
    if (we_i) tag_q[widx_i] <= wtag_i;
endmodule

// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped write-through, write-allocate L1 data cache in front of L2.
// Optional hit/miss counters are built when L1_STATS_EN is defined.
module l1_dcache import l1_cache_pkg::*; #(
  parameter int DATA_WIDTH = L1_DATA_WIDTH,
  parameter int ADDR_WIDTH = L1_ADDR_WIDTH,
  parameter int BLOCK_SIZE = L1_BLOCK_SIZE,
  parameter int NUM_LINES  = L1_NUM_LINES
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cpu_req,
  input  logic                             cpu_we,
  input  logic [ADDR_WIDTH-1:0]            cpu_addr,
  input  logic [DATA_WIDTH-1:0]            cpu_wdata,
  output logic [DATA_WIDTH-1:0]            cpu_rdata,
  output logic                             cpu_ready,
  output logic [ADDR_WIDTH-1:0]            l2_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_block_out,
  output logic                             l2_read,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_block_in,
  input  logic                             l2_ready,
`ifdef L1_STATS_EN
  output logic [15:0]                      hit_count,
  output logic [15:0]                      miss_count,
`endif
  output logic                             l2_write
);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, l2a_q, l2a_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic                  we_q, we_d, rd_q, rd_d, wr_q, wr_d, ready_q;
  block_t                blk_q, blk_d, line_d, fill;
  block_t                lines_q [NUM_LINES];
  logic                  line_we, tag_we, hit, accept;
  logic [INDEX_W-1:0]    c_idx, q_idx, line_idx;
  logic [OFFSET_W-1:0]   c_off, q_off;
  logic [TAG_W-1:0]      c_tag, q_tag;
  assign c_off  = cpu_addr[OFFSET_W-1:0];
  assign c_idx  = cpu_addr[OFFSET_W +: INDEX_W];
  assign c_tag  = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
  assign q_off  = addr_q[OFFSET_W-1:0];
  assign q_idx  = addr_q[OFFSET_W +: INDEX_W];
  assign q_tag  = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign fill   = l2_block_in;
  assign accept = state_q == IDLE && cpu_req;
  l1_tag_array u_tags (
    .clk    (clk),
    .rst_n  (rst_n),
    .idx_i  (c_idx),
    .tag_i  (c_tag),
    .hit_o  (hit),
    .we_i   (tag_we),
    .widx_i (q_idx),
    .wtag_i (q_tag)
  );
  // Lookup uses the live CPU address; refill uses the latched one.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    l2a_d    = l2a_q;
    blk_d    = blk_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    line_we  = 1'b0;
    tag_we   = 1'b0;
    line_idx = q_idx;
    line_d   = lines_q[q_idx];
    case (state_q)
      IDLE: if (cpu_req) begin
        addr_d   = cpu_addr;
        we_d     = cpu_we;
        wdata_d  = cpu_wdata;
        l2a_d    = {cpu_addr[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
        line_idx = c_idx;
        line_d   = lines_q[c_idx];
        line_d[c_off] = cpu_wdata;
        if (!hit) begin
          rd_d    = 1'b1;
          state_d = L2_READ;
        end else if (cpu_we) begin
          line_we = 1'b1;
          blk_d   = line_d;
          wr_d    = 1'b1;
          state_d = L2_WRITE;
        end else begin
          rdata_d = lines_q[c_idx][c_off];
          state_d = RESP;
        end
      end
      L2_READ: if (l2_ready) begin
        line_d = fill;
        if (we_q) line_d[q_off] = wdata_q;
        line_we = 1'b1;
        tag_we  = 1'b1;
        rd_d    = 1'b0;
        wr_d    = we_q;
        blk_d   = we_q ? line_d : blk_q;
        rdata_d = we_q ? rdata_q : fill[q_off];
        state_d = we_q ? L2_WRITE : RESP;
      end
      L2_WRITE: if (l2_ready) begin
        wr_d    = 1'b0;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      l2a_q   <= '0;
      blk_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      l2a_q   <= l2a_d;
      blk_q   <= blk_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ready_q <= state_q == RESP;
    end
  always_ff @(posedge clk)
    if (line_we) lines_q[line_idx] <= line_d;
  assign cpu_rdata    = rdata_q;
  assign cpu_ready    = ready_q;
  assign l2_addr      = l2a_q;
  assign l2_block_out = blk_q;
  assign l2_read      = rd_q;
  assign l2_write     = wr_q;
`ifdef L1_STATS_EN
  logic [15:0] hit_q, miss_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      hit_q  <= hit_q + {15'b0, accept && hit && hit_q != 16'hFFFF};
      miss_q <= miss_q + {15'b0, accept && !hit && miss_q != 16'hFFFF};
    end
  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif
endmodule

// File: tb/tb_l1_dcache.sv
// tb_l1_dcache: directed checks of hits, misses, write-through merging, conflicts and async reset.
module tb_l1_dcache;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0, l2_ready = 1'b0;
  logic [10:0]   cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic [31:0]   cpu_rdata;
  logic          cpu_ready, l2_read, l2_write;
  logic [10:0]   l2_addr;
  logic [1023:0] l2_block_out;
  logic [1023:0] l2_block_in = '0;
`ifdef L1_STATS_EN
  logic [15:0]   hit_count, miss_count;
`endif
  logic [31:0]   mem [2048];
  int            n_assert = 0, n_fail = 0;
  int            cyc;
  logic          rd_seen, wr_seen, both, timeout;
  logic [10:0]   rd_addr, wr_addr;
  logic [1023:0] wr_blk;

  always #5 clk = ~clk;

  l1_dcache dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ready    (cpu_ready),
    .l2_addr      (l2_addr),
    .l2_block_out (l2_block_out),
    .l2_read      (l2_read),
    .l2_block_in  (l2_block_in),
    .l2_ready     (l2_ready),
`ifdef L1_STATS_EN
    .hit_count    (hit_count),
    .miss_count   (miss_count),
`endif
    .l2_write     (l2_write)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1023:0] blk_of(input logic [10:0] a);
    logic [1023:0] r;
    for (int k = 0; k < 32; k++) r[k*32 +: 32] = mem[int'(a) + k];
    return r;
  endfunction

  // One CPU access; the L2 side answers each strobe after lat cycles (lat=1: same cycle).
  task automatic access(input logic we, input logic [10:0] a, input logic [31:0] d, input int lat);
    int rc, wc;
    rc = 0; wc = 0; rd_seen = 0; wr_seen = 0; both = 0; timeout = 0;
    rd_addr = '0; wr_addr = '0; wr_blk = '0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cyc = 1;
    while (!cpu_ready && !timeout) begin
      if (l2_read && l2_write) both = 1'b1;
      if (l2_read) begin
        rd_seen = 1'b1; rd_addr = l2_addr; rc++;
        if (rc >= lat) begin l2_block_in = blk_of(l2_addr); l2_ready = 1'b1; end
      end
      if (l2_write) begin
        wr_seen = 1'b1; wr_addr = l2_addr; wr_blk = l2_block_out; wc++;
        if (wc >= lat) begin
          for (int k = 0; k < 32; k++) mem[int'(l2_addr) + k] = l2_block_out[k*32 +: 32];
          l2_ready = 1'b1;
        end
      end
      @(negedge clk);
      l2_ready = 1'b0;
      cyc++;
      if (cyc > 100) timeout = 1'b1;
    end
    chk("no_timeout", {31'b0, timeout}, 32'd0);
    chk("no_dual_strobe", {31'b0, both}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h1000 + (i % 32);
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", {31'b0, cpu_ready}, 32'd0);
    chk("rst_l2_read", {31'b0, l2_read}, 32'd0);
    chk("rst_l2_write", {31'b0, l2_write}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_l2_addr", {21'b0, l2_addr}, 32'd0);
    chk("rst_block_out", {31'b0, |l2_block_out}, 32'd0);
    rst_n = 1'b1;
`ifdef L1_STATS_EN
    chk("rst_hits", {16'b0, hit_count}, 32'd0);
    chk("rst_misses", {16'b0, miss_count}, 32'd0);
`endif
    // cold load miss
    access(1'b0, 11'h045, 32'h0, 3);
    chk("cold_rd_seen", {31'b0, rd_seen}, 32'd1);
    chk("cold_rd_addr", {21'b0, rd_addr}, 32'h040);
    chk("cold_no_write", {31'b0, wr_seen}, 32'd0);
    chk("cold_rdata", cpu_rdata, 32'h1005);
    chk("cold_latency", cyc, 32'd5);
`ifdef L1_STATS_EN
    chk("cold_hits", {16'b0, hit_count}, 32'd0);
    chk("cold_misses", {16'b0, miss_count}, 32'd1);
`endif
    // load hit
    access(1'b0, 11'h045, 32'h0, 3);
    chk("hit_no_read", {31'b0, rd_seen}, 32'd0);
    chk("hit_no_write", {31'b0, wr_seen}, 32'd0);
    chk("hit_latency", cyc, 32'd2);
    chk("hit_rdata", cpu_rdata, 32'h1005);
`ifdef L1_STATS_EN
    chk("hit_hits", {16'b0, hit_count}, 32'd1);
    chk("hit_misses", {16'b0, miss_count}, 32'd1);
`endif
    // store hit, write-through
    access(1'b1, 11'h047, 32'hDEAD, 2);
    chk("sthit_no_read", {31'b0, rd_seen}, 32'd0);
    chk("sthit_write", {31'b0, wr_seen}, 32'd1);
    chk("sthit_wr_addr", {21'b0, wr_addr}, 32'h040);
    chk("sthit_word7", wr_blk[7*32 +: 32], 32'hDEAD);
    chk("sthit_word6", wr_blk[6*32 +: 32], 32'h1006);
    chk("sthit_word0", wr_blk[0 +: 32], 32'h1000);
    chk("sthit_latency", cyc, 32'd4);
    chk("sthit_rdata_held", cpu_rdata, 32'h1005);
    access(1'b0, 11'h047, 32'h0, 2);
    chk("ld047_no_read", {31'b0, rd_seen}, 32'd0);
    chk("ld047_rdata", cpu_rdata, 32'hDEAD);
    // store miss with same-cycle l2_ready
    access(1'b1, 11'h3A2, 32'hBEEF, 1);
    chk("stmiss_read", {31'b0, rd_seen}, 32'd1);
    chk("stmiss_rd_addr", {21'b0, rd_addr}, 32'h3A0);
    chk("stmiss_write", {31'b0, wr_seen}, 32'd1);
    chk("stmiss_wr_addr", {21'b0, wr_addr}, 32'h3A0);
    chk("stmiss_word2", wr_blk[2*32 +: 32], 32'hBEEF);
    chk("stmiss_word3", wr_blk[3*32 +: 32], 32'h1003);
    chk("stmiss_latency", cyc, 32'd4);
    access(1'b0, 11'h3A2, 32'h0, 2);
    chk("ld3a2_no_read", {31'b0, rd_seen}, 32'd0);
    chk("ld3a2_rdata", cpu_rdata, 32'hBEEF);
    chk("ld3a2_latency", cyc, 32'd2);
    // conflict on index 2
    access(1'b0, 11'h445, 32'h0, 2);
    chk("conf_read", {31'b0, rd_seen}, 32'd1);
    chk("conf_rd_addr", {21'b0, rd_addr}, 32'h440);
    chk("conf_rdata", cpu_rdata, 32'h1005);
    access(1'b0, 11'h047, 32'h0, 2);
    chk("evict_read", {31'b0, rd_seen}, 32'd1);
    chk("evict_rd_addr", {21'b0, rd_addr}, 32'h040);
    chk("evict_rdata", cpu_rdata, 32'hDEAD);
    access(1'b0, 11'h3A2, 32'h0, 2);
    chk("other_line_kept", {31'b0, rd_seen}, 32'd0);
    // asynchronous reset during L2_READ
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h0A5;
    @(negedge clk);
    cpu_req = 1'b0; cpu_addr = '0;
    chk("pre_rst_read", {31'b0, l2_read}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_read", {31'b0, l2_read}, 32'd0);
    chk("async_rst_write", {31'b0, l2_write}, 32'd0);
    chk("async_rst_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 11'h045, 32'h0, 2);
    chk("post_rst_miss", {31'b0, rd_seen}, 32'd1);
    chk("post_rst_rdata", cpu_rdata, 32'h1005);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
